// File: rtl/f8_gpio_pkg.sv
// rtl/f8_gpio_pkg.sv - shared types and constants for the f8 gpio serial receiver
//
// Purpose: receiver FSM state encoding and the frame data width used by
//          gpio_uart_rx and its testbench.
// Ports:   none (package).
package f8_gpio_pkg;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/gpio_rx_fifo.sv
// rtl/gpio_rx_fifo.sv - small byte FIFO with a registered head-of-queue output
//
// Purpose: buffers received bytes between the serial FSM and the consumer.
//          rdata_o is a register that always holds the current head entry
//          and keeps its last value when the FIFO drains.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push_i      write wdata_i (dropped when full unless popping this cycle)
//   wdata_i     data to write
//   pop_i       remove the head entry (ignored when empty)
//   rdata_o     head entry, registered
//   full_o      FIFO holds DEPTH entries
//   empty_o     FIFO holds no entries
//   count_o     number of entries held
module gpio_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = rdata_q;

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The new head is the incoming byte when it becomes the only entry,
        // otherwise the next stored entry when the current head is popped.
        if (do_push && (count_q == '0 || (do_pop && count_q == CW'(1)))) begin
            rdata_d = wdata_i;
        end else if (do_pop && count_q > CW'(1)) begin
            rdata_d = mem_q[rd_ptr_q + AW'(1)];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: rtl/gpio_uart_rx.sv
// rtl/gpio_uart_rx.sv - 8N1 serial receiver on one selectable gpio pin
//
// Purpose: samples gpio_pins[pin_sel] as an asynchronous serial line,
//          reassembles bytes LSB first, buffers them in gpio_rx_fifo and
//          reports sticky framing-error and overrun flags.
// Ports:
//   clk               system clock
//   power_on_reset_n  asynchronous active-low reset (released synchronously)
//   gpio_pins         gpio pin bus
//   pin_sel           index of the serial data pin
//   enable            receiver enable
//   rx_data           head-of-FIFO byte
//   rx_valid          FIFO non-empty
//   rx_ready          consumer accepts rx_data on rx_valid && rx_ready
//   frame_error       sticky, stop bit sampled low
//   overrun           sticky, byte dropped on a full FIFO
//   clear_errors      clears both sticky flags
module gpio_uart_rx
    import f8_gpio_pkg::*;
#(
    parameter int CLK_PER_BIT = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int PIN_WIDTH   = 8,
    localparam int SEL_W = (PIN_WIDTH > 1) ? $clog2(PIN_WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 power_on_reset_n,
    input  logic [PIN_WIDTH-1:0] gpio_pins,
    input  logic [SEL_W-1:0]     pin_sel,
    input  logic                 enable,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 overrun,
    input  logic                 clear_errors
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    // Reset bridge: assertion is immediate, release waits two clock edges.
    logic rst_meta_q;
    logic rst_n;

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            rst_meta_q <= 1'b0;
            rst_n      <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n      <= rst_meta_q;
        end
    end

    uart_state_t               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic                      sync1_q, sync2_q, hist_q;
    logic                      frame_error_q, overrun_q;

    logic             line;
    logic             start_edge;
    logic             cnt_zero;
    logic [SEL_W-1:0] sel_eff;
    logic             byte_push;
    logic             fe_set;
    logic             ovf_set;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;

    // While a frame is in flight the pin captured at start detection is used,
    // so pin_sel changes cannot corrupt the byte being received.
    assign sel_eff    = (state_q == UART_IDLE) ? pin_sel : sel_q;
    assign line       = sync2_q;
    assign start_edge = !sync2_q && hist_q;
    assign cnt_zero   = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= gpio_pins[sel_eff];
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UART_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = UART_IDLE;
        end else begin
            case (state_q)
                UART_IDLE:  if (start_edge) state_d = UART_START;
                UART_START: if (cnt_zero) state_d = line ? UART_IDLE : UART_DATA;
                UART_DATA:  if (cnt_zero && bit_idx_q == LAST_BIT) state_d = UART_STOP;
                UART_STOP:  if (cnt_zero) state_d = UART_IDLE;
                default:    state_d = UART_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        sel_d     = sel_q;
        byte_push = 1'b0;
        fe_set    = 1'b0;
        if (enable) begin
            case (state_q)
                UART_IDLE: begin
                    if (start_edge) begin
                        cnt_d = HALF_BIT;
                        sel_d = pin_sel;
                    end
                end
                UART_START: begin
                    if (cnt_zero) begin
                        cnt_d     = FULL_BIT;
                        bit_idx_d = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                UART_DATA: begin
                    if (cnt_zero) begin
                        shift_d   = {line, shift_q[UART_DATA_BITS-1:1]};
                        cnt_d     = FULL_BIT;
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                UART_STOP: begin
                    if (cnt_zero) begin
                        byte_push = line;
                        fe_set    = !line;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            sel_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            sel_q     <= sel_d;
        end
    end

    assign fifo_pop = rx_ready && !fifo_empty;
    assign ovf_set  = byte_push && fifo_full && !fifo_pop;

    gpio_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (byte_push),
        .wdata_i (shift_q),
        .pop_i   (fifo_pop),
        .rdata_o (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rx_valid = (fifo_count != '0);

    // A set event in the same cycle as clear_errors wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (fe_set) begin
                frame_error_q <= 1'b1;
            end else if (clear_errors) begin
                frame_error_q <= 1'b0;
            end
            if (ovf_set) begin
                overrun_q <= 1'b1;
            end else if (clear_errors) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/gpio_uart_rx.md
Name: gpio_uart_rx

Overview:
- Serial receiver on the gpio side of the f8 system.
- Consumes one bit of the system's gpio pin bus as an 8N1 asynchronous serial line.
- Reassembles bytes LSB-first, buffers them in a small FIFO, and presents them on a valid/ready interface to the test harness or a downstream consumer.
- Reports framing errors and overruns, so firmware output written bit-banged to a gpio port can be checked byte-wise.

Parameters:
- CLK_PER_BIT, 16, clk cycles per serial bit; even, >= 4.
- FIFO_DEPTH, 4, byte entries; power of two, >= 2.
- PIN_WIDTH, 8, width of the gpio pin bus.

Ports:
- clk  input  1  system clock; all state on posedge.
- power_on_reset_n  input  1  asynchronous, active-low reset.
- gpio_pins  input  PIN_WIDTH  gpio pin bus from the system (e.g. gpio0pins).
- pin_sel  input  $clog2(PIN_WIDTH)  index of the pin carrying serial data.
- enable  input  1  receiver enable.
- rx_data  output  8  head-of-FIFO byte.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_error  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- clear_errors  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; FIFO empty.
  - rx_valid=0, rx_data=8'h00, frame_error=0, overrun=0.
  - Synchroniser flops preset to 1 (line idle).
- Input path:
  - gpio_pins[pin_sel] passes through a 2-flop synchroniser, then one edge-history flop.
  - pin_sel is captured at start detection and held for the whole frame.
- IDLE:
  - Start is detected when the synchronised line = 0 and the previous sample = 1, with enable=1.
  - On start: bit counter loads CLK_PER_BIT/2-1, state goes to START.
- START:
  - Counter decrements each cycle.
  - At 0, if the line = 0: go to DATA, counter = CLK_PER_BIT-1, bit index = 0.
  - At 0, if the line = 1: false start; return to IDLE with no flag set.
- DATA:
  - At counter 0, the line is shifted into the shift register MSB, shifting right (LSB first); counter reloads.
  - After the 8th sample, go to STOP.
- STOP, sampled at counter 0:
  - Line = 1: byte pushed to the FIFO.
  - Line = 0: byte discarded, frame_error set.
  - Either case: return to IDLE. A new start needs the line to return high first, because edge detection is used.
- Latency: rx_valid rises the cycle after the stop sample when the FIFO was empty.
- FIFO:
  - rx_data = head entry, registered, not fall-through beyond that cycle.
  - Pop on rx_valid && rx_ready.
  - Push while full with no pop in the same cycle: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun.
  - Push and pop in the same cycle while empty: push only (pop is impossible since rx_valid=0).
  - Pointers wrap modulo FIFO_DEPTH; a separate count disambiguates full from empty.
- enable deasserted:
  - FSM forced to IDLE; any partial byte is discarded.
  - FIFO contents and flags are retained; popping continues to work.
- Sticky flags: clear_errors clears both. If a set event and clear_errors occur in the same cycle, the set wins.
- rx_data holds its value when rx_valid=0. It is not cleared on pop.

Decomposition:
- Shared package f8_gpio_pkg holds:
  - typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t.
  - localparam UART_DATA_BITS = 8.
- One natural sub-module, gpio_rx_fifo, parameterised by depth and width, with push/pop/full/empty/count ports.
- The FSM, synchroniser and flags stay in gpio_uart_rx.

Test Plan:
- Reset, then an idle-high line: rx_valid=0, rx_data=8'h00 and both flags 0 for 200 cycles; a reset pulse mid-frame returns the block to IDLE with the FIFO empty.
- CLK_PER_BIT=16, pin_sel=0: send 8'h55 then 8'hA3 back-to-back with rx_ready=1.
  - rx_data=8'h55 then 8'hA3, one rx_valid handshake each.
  - rx_valid rises the cycle after the stop sample.
  - frame_error=0.
- Glitch low for 5 cycles on the line: no byte, no flag, FSM back in IDLE; a following 8'h0F is received correctly.
- Send 8'hFF with the stop bit driven low: no push, frame_error=1; clear_errors clears it; next byte 8'h3C received.
- rx_ready=0, send 5 bytes 8'h01..8'h05 (FIFO_DEPTH=4):
  - overrun=1.
  - Then rx_ready=1 yields 01,02,03,04 only.
- Keep the FIFO full and pop on the exact cycle the 5th byte is pushed: no overrun, and 5 bytes drain in order.
- pin_sel=3: serial data on gpio_pins[3] decodes; toggling other pins has no effect. Changing pin_sel mid-frame does not corrupt the frame.
